// File: rtl/boot_pkg.sv
// Shared types and defaults for the UART boot loader.
//   boot_state_e : frame-parser states
//   boot_err_e   : err_code encoding reported on the top-level port
//   BOOT_SYNC_BYTE / BOOT_TIMEOUT_CYC : default parameter values
package boot_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR0,
        S_ADDR1,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } boot_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_ALIGN    = 2'd1,
        ERR_RANGE    = 2'd2,
        ERR_TMO_CSUM = 2'd3
    } boot_err_e;

    localparam logic [7:0] BOOT_SYNC_BYTE   = 8'hA5;
    localparam int         BOOT_TIMEOUT_CYC = 1000000;

endpackage

// File: rtl/boot_word_pack.sv
// Byte-to-word packer. Bytes fill lanes 0..BPW-1 (little-endian); the
// registered word_valid_o pulses the cycle after the byte that fills the
// last lane, with the complete word on word_o.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   clear_i         : restart at lane 0 (new frame)
//   byte_valid_i    : byte strobe
//   byte_i          : byte to place in the current lane
//   last_lane_o     : current lane is the final one (next byte completes a word)
//   word_valid_o    : one-cycle word-complete strobe
//   word_o          : assembled word
module boot_word_pack #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic              last_lane_o,
    output logic              word_valid_o,
    output logic [DATA_W-1:0] word_o
);

    localparam int BPW = DATA_W / 8;
    localparam int LW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [LW-1:0]     lane_q;
    logic [DATA_W-1:0] word_q;
    logic              word_valid_q;

    assign last_lane_o  = (lane_q == LW'(BPW - 1));
    assign word_valid_o = word_valid_q;
    assign word_o       = word_q;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            lane_q       <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            word_valid_q <= byte_valid_i && last_lane_o;
            if (byte_valid_i) begin
                for (int i = 0; i < BPW; i++) begin
                    if (lane_q == LW'(i)) word_q[i*8 +: 8] <= byte_i;
                end
                lane_q <= last_lane_o ? '0 : lane_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// Framed program loader: parses SYNC, ADDR(16), LEN(16, words), payload
// and (optionally) CSUM from the UART byte stream and writes assembled
// words to memory. The CPU is held until a frame completes cleanly.
// Optional feature macro: BOOT_CHECKSUM_EN (trailing CSUM byte checked;
// when undefined the frame ends with the last payload word).
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   rx_valid, rx_data     : received byte strobe / byte
//   mem_we, mem_addr,
//   mem_wdata             : word write port (byte address, BPW-aligned)
//   cpu_hold              : hold CPU in reset while 1
//   busy, done, error     : frame status
//   err_code              : 0 none, 1 misaligned, 2 out of range, 3 timeout/csum
//   word_count            : words written in current/last frame
//   status_led            : last received byte
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter int         DATA_W      = 32,
    parameter int         ADDR_W      = 10,
    parameter logic [7:0] SYNC_BYTE   = BOOT_SYNC_BYTE,
    parameter int         TIMEOUT_CYC = BOOT_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [15:0]       word_count,
    output logic [7:0]        status_led
);

    localparam int BPW = DATA_W / 8;
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);
    // Range check width: ADDR + LEN*BPW must never wrap.
    localparam int RW  = ADDR_W + 16 + $clog2(BPW + 1) + 1;

    boot_state_e       state_q;
    boot_err_e         err_code_q;
    logic [7:0]        addr_lo_q, len_lo_q, status_led_q;
    logic [ADDR_W-1:0] base_q, mem_addr_q;
    logic [15:0]       len_q, word_count_q;
    logic [TW-1:0]     tmo_q;
    logic              cpu_hold_q, busy_q, done_q, error_q;

    logic              start, feed, aligned, range_bad, last_word, tmo_hit;
    logic              pack_last;
    logic [ADDR_W-1:0] base_in;
    logic [15:0]       len_in;

    assign base_in   = ADDR_W'({rx_data, addr_lo_q});
    assign len_in    = {rx_data, len_lo_q};
    assign aligned   = (base_in % ADDR_W'(BPW)) == '0;
    assign range_bad = (RW'(base_q) + RW'(len_in) * RW'(BPW)) > (RW'(1) << ADDR_W);
    assign last_word = (word_count_q + 16'd1) == len_q;
    assign start     = rx_valid && (rx_data == SYNC_BYTE) &&
                       (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
    assign feed      = rx_valid && (state_q == S_DATA);
    // A byte arriving on the expiry cycle wins over the timeout.
    assign tmo_hit   = busy_q && !rx_valid && (tmo_q == TW'(TIMEOUT_CYC - 1));

`ifdef BOOT_CHECKSUM_EN
    logic [7:0] sum_q;
    logic       csum_ok;
    assign csum_ok = 8'(sum_q + rx_data) == 8'h00;
`endif

    boot_word_pack #(.DATA_W(DATA_W)) u_pack (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (start),
        .byte_valid_i (feed),
        .byte_i       (rx_data),
        .last_lane_o  (pack_last),
        .word_valid_o (mem_we),
        .word_o       (mem_wdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            err_code_q   <= ERR_NONE;
            addr_lo_q    <= '0;
            len_lo_q     <= '0;
            status_led_q <= '0;
            base_q       <= '0;
            mem_addr_q   <= '0;
            len_q        <= '0;
            word_count_q <= '0;
            tmo_q        <= '0;
            cpu_hold_q   <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            if (rx_valid) status_led_q <= rx_data;

            if (rx_valid || !busy_q) tmo_q <= '0;
            else                     tmo_q <= tmo_q + 1'b1;

`ifdef BOOT_CHECKSUM_EN
            if (start)                  sum_q <= '0;
            else if (rx_valid && busy_q) sum_q <= sum_q + rx_data;
`endif

            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state_q      <= S_ADDR0;
                        cpu_hold_q   <= 1'b1;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        error_q      <= 1'b0;
                        err_code_q   <= ERR_NONE;
                        word_count_q <= '0;
                    end
                end
                default: begin
                    if (rx_valid) begin
                        case (state_q)
                            S_ADDR0: begin
                                addr_lo_q <= rx_data;
                                state_q   <= S_ADDR1;
                            end
                            S_ADDR1: begin
                                if (!aligned) begin
                                    state_q    <= S_ERROR;
                                    error_q    <= 1'b1;
                                    busy_q     <= 1'b0;
                                    err_code_q <= ERR_ALIGN;
                                end else begin
                                    base_q  <= base_in;
                                    state_q <= S_LEN0;
                                end
                            end
                            S_LEN0: begin
                                len_lo_q <= rx_data;
                                state_q  <= S_LEN1;
                            end
                            S_LEN1: begin
                                len_q <= len_in;
                                if (range_bad) begin
                                    state_q    <= S_ERROR;
                                    error_q    <= 1'b1;
                                    busy_q     <= 1'b0;
                                    err_code_q <= ERR_RANGE;
                                end else if (len_in != 16'd0) begin
                                    state_q <= S_DATA;
                                end else begin
`ifdef BOOT_CHECKSUM_EN
                                    state_q <= S_CSUM;
`else
                                    state_q    <= S_DONE;
                                    done_q     <= 1'b1;
                                    cpu_hold_q <= 1'b0;
                                    busy_q     <= 1'b0;
`endif
                                end
                            end
                            S_DATA: begin
                                // Word completes now; the packer drives mem_we
                                // next cycle, aligned with these registers.
                                if (pack_last) begin
                                    mem_addr_q   <= base_q + ADDR_W'(int'(word_count_q) * BPW);
                                    word_count_q <= word_count_q + 16'd1;
                                    if (last_word) begin
`ifdef BOOT_CHECKSUM_EN
                                        state_q <= S_CSUM;
`else
                                        state_q    <= S_DONE;
                                        done_q     <= 1'b1;
                                        cpu_hold_q <= 1'b0;
                                        busy_q     <= 1'b0;
`endif
                                    end
                                end
                            end
`ifdef BOOT_CHECKSUM_EN
                            S_CSUM: begin
                                busy_q <= 1'b0;
                                if (csum_ok) begin
                                    state_q    <= S_DONE;
                                    done_q     <= 1'b1;
                                    cpu_hold_q <= 1'b0;
                                end else begin
                                    state_q    <= S_ERROR;
                                    error_q    <= 1'b1;
                                    err_code_q <= ERR_TMO_CSUM;
                                end
                            end
`endif
                            default: state_q <= S_IDLE;
                        endcase
                    end else if (tmo_hit) begin
                        state_q    <= S_ERROR;
                        error_q    <= 1'b1;
                        busy_q     <= 1'b0;
                        err_code_q <= ERR_TMO_CSUM;
                    end
                end
            endcase
        end
    end

    assign mem_addr   = mem_addr_q;
    assign cpu_hold   = cpu_hold_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign err_code   = err_code_q;
    assign word_count = word_count_q;
    assign status_led = status_led_q;

endmodule
